// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx -- serial frame transmitter.
//
// On a start request in IDLE, the payload (pat) and its length (len) are
// captured into shadow registers. The block then shifts out a fixed 3-bit
// header (HDR, MSB first), followed by len+1 payload bits taken from
// pat_shadow[len] down to pat_shadow[0]. A one-cycle DONE state follows the
// last payload bit. Each bit is held until step=1 at a rising edge. abort
// cancels a frame in HDR or DATA. All outputs are decoded from registered
// state only (Moore).
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - frame request, sampled only in IDLE
//   step   - bit-advance enable
//   abort  - synchronous frame cancel (HDR/DATA only), wins over step
//   pat    - payload bits, captured at start
//   len    - payload length minus one, captured at start
//   outp   - serial bit stream
//   valid  - outp carries a header or payload bit
//   busy   - high in HDR, DATA and DONE
//   done   - one-cycle pulse after the last payload bit
module seq_pattern_tx #(
  parameter int         PAT_W = 16,
  parameter logic [2:0] HDR   = 3'b001
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic                     abort,
  input  logic [PAT_W-1:0]         pat,
  input  logic [$clog2(PAT_W)-1:0] len,
  output logic                     outp,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W   = $clog2(PAT_W);
  localparam int PAT_EXT = 1 << LEN_W;

  // IDLE is the all-zero encoding so power-up and reset state coincide.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   idx, idx_nx;
  logic [LEN_W-1:0]   len_sh, len_nx;
  logic [PAT_W-1:0]   pat_sh, pat_nx;

  // Payload padded to a power of two so any idx value selects a defined bit
  // (a len beyond PAT_W-1 for non-power-of-two widths then sends zeros).
  logic [PAT_EXT-1:0] pat_ext;
  logic [3:0]         hdr_ext;

  assign pat_ext = PAT_EXT'(pat_sh);
  assign hdr_ext = {1'b0, HDR};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      len_sh <= '0;
      pat_sh <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      len_sh <= len_nx;
      pat_sh <= pat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    len_nx   = len_sh;
    pat_nx   = pat_sh;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pat_nx   = pat;
          len_nx   = len;
          idx_nx   = LEN_W'(2);
          state_nx = S_HDR;
        end
      end
      S_HDR: begin
        if (abort) begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end else if (step) begin
          if (idx == '0) begin
            state_nx = S_DATA;
            idx_nx   = len_sh;
          end else begin
            idx_nx = idx - LEN_W'(1);
          end
        end
      end
      S_DATA: begin
        if (abort) begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end else if (step) begin
          if (idx == '0) begin
            state_nx = S_DONE;
          end else begin
            idx_nx = idx - LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    outp  = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_HDR: begin
        // idx never exceeds 2 in HDR, so the low two bits suffice.
        outp  = hdr_ext[idx[1:0]];
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_DATA: begin
        outp  = pat_ext[idx];
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
